// File: rtl/bcd_converter.sv
// Sequential binary-to-packed-BCD converter (shift-add-3).
// One double-dabble iteration per clock, start/done handshake,
// saturation to all nines with an overflow flag, and a leading-zero
// blank mask for the seven-segment display driver.
module bcd_converter #(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Start,
   input  logic [WIDTH-1:0]    DataIn,
   output logic                Busy,
   output logic                Done,
   output logic [4*DIGITS-1:0] BcdOut,
   output logic                Overflow,
   output logic [DIGITS-1:0]   BlankMask
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [CNT_W-1:0]  CNT_LOAD    = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
   // Every digit blanked except the least significant one.
   localparam logic [DIGITS-1:0] BLANK_RESET = ~(DIGITS'(1));

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t              state_q,   state_d;
   logic [WIDTH-1:0]    shreg_q,   shreg_d;
   logic [BCD_W-1:0]    scratch_q, scratch_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic                ovf_q,     ovf_d;
   logic [BCD_W-1:0]    bcd_q,     bcd_d;
   logic                ovf_out_q, ovf_out_d;
   logic [DIGITS-1:0]   blank_q,   blank_d;

   logic [BCD_W-1:0]    scratch_adj;
   logic [BCD_W-1:0]    scratch_shift;
   logic                ovf_next;
   logic [BCD_W-1:0]    result_bcd;
   logic [DIGITS-1:0]   result_mask;
   logic                zero_above;
   logic                load;

   // Add-3 correction: any digit of 5 or more is bumped so the shift carries into the next digit.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      scratch_adj = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // One iteration's shift, sticky overflow, and the saturated result/blank mask it would yield.
   always_comb begin
      scratch_shift = {scratch_adj[BCD_W-2:0], shreg_q[WIDTH-1]};
      ovf_next      = ovf_q | scratch_adj[BCD_W-1];
      result_bcd    = ovf_next ? {DIGITS{4'h9}} : scratch_shift;
      result_mask   = '0;
      zero_above    = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above     = zero_above & (result_bcd[4*i +: 4] == 4'h0);
         result_mask[i] = zero_above;
      end
   end

   // Next-state, datapath update and handshake outputs.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      bcd_d     = bcd_q;
      ovf_out_d = ovf_out_q;
      blank_d   = blank_q;
      Busy      = 1'b0;
      Done      = 1'b0;
      load      = 1'b0;

      case (state_q)
         IDLE: begin
            load = Start;
         end
         SHIFT: begin
            Busy      = 1'b1;
            shreg_d   = shreg_q << 1;
            scratch_d = scratch_shift;
            ovf_d     = ovf_next;
            cnt_d     = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d   = DONE;
               bcd_d     = result_bcd;
               ovf_out_d = ovf_next;
               blank_d   = result_mask;
            end
         end
         DONE: begin
            Done    = 1'b1;
            state_d = IDLE;
            load    = Start;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new operand is accepted from IDLE, or straight out of DONE for back-to-back use.
      if (load) begin
         state_d   = SHIFT;
         shreg_d   = DataIn;
         scratch_d = '0;
         ovf_d     = 1'b0;
         cnt_d     = CNT_LOAD;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!Reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         bcd_q     <= '0;
         ovf_out_q <= 1'b0;
         blank_q   <= BLANK_RESET;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         bcd_q     <= bcd_d;
         ovf_out_q <= ovf_out_d;
         blank_q   <= blank_d;
      end
   end

   assign BcdOut    = bcd_q;
   assign Overflow  = ovf_out_q;
   assign BlankMask = blank_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Self-checking bench for bcd_converter: a 14-bit/4-digit instance for
// directed, random, handshake and reset scenarios, and a 6-bit/2-digit
// instance swept exhaustively. Expected values come from a decimal
// arithmetic model (division and modulo by ten).
module tb_bcd_converter;

   localparam int WA = 14;
   localparam int DA = 4;
   localparam int WB = 6;
   localparam int DB = 2;

   logic            clk = 1'b0;
   logic            rst_n;

   logic            start_a;
   logic [WA-1:0]   din_a;
   logic            busy_a, done_a, ovf_a;
   logic [4*DA-1:0] bcd_a;
   logic [DA-1:0]   mask_a;

   logic            start_b;
   logic [WB-1:0]   din_b;
   logic            busy_b, done_b, ovf_b;
   logic [4*DB-1:0] bcd_b;
   logic [DB-1:0]   mask_b;

   int              n_vec = 0;
   int              n_err = 0;
   int              overlap = 0;
   logic [31:0]     prev_bcd_a;

   always #5 clk = ~clk;

   bcd_converter #(.WIDTH(WA), .DIGITS(DA)) u_dut_a (
      .Clk       (clk),
      .Reset     (rst_n),
      .Start     (start_a),
      .DataIn    (din_a),
      .Busy      (busy_a),
      .Done      (done_a),
      .BcdOut    (bcd_a),
      .Overflow  (ovf_a),
      .BlankMask (mask_a)
   );

   bcd_converter #(.WIDTH(WB), .DIGITS(DB)) u_dut_b (
      .Clk       (clk),
      .Reset     (rst_n),
      .Start     (start_b),
      .DataIn    (din_b),
      .Busy      (busy_b),
      .Done      (done_b),
      .BcdOut    (bcd_b),
      .Overflow  (ovf_b),
      .BlankMask (mask_b)
   );

   // Busy and Done must never be high together on either instance.
   always @(negedge clk) begin
      if ((busy_a && done_a) || (busy_b && done_b)) overlap++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Decimal reference: saturate above 10^digits-1, otherwise peel digits with %10,
   // and blank every digit above the most significant nonzero one (digit 0 always shown).
   function automatic void ref_model(input int unsigned v, input int digits,
                                     output logic [31:0] bcd, output logic ovf,
                                     output logic [31:0] mask);
      int unsigned lim = 1;
      int unsigned t;
      int          nd;
      for (int i = 0; i < digits; i++) lim = lim * 10;
      bcd  = '0;
      mask = '0;
      if (v >= lim) begin
         ovf = 1'b1;
         for (int i = 0; i < digits; i++) bcd[4*i +: 4] = 4'h9;
      end else begin
         ovf = 1'b0;
         t = v;
         for (int i = 0; i < digits; i++) begin
            bcd[4*i +: 4] = 4'(t % 10);
            t = t / 10;
         end
         nd = 1;
         t  = v;
         while (t >= 10) begin
            t = t / 10;
            nd++;
         end
         for (int i = nd; i < digits; i++) mask[i] = 1'b1;
      end
   endfunction

   // Steps negedges until Done on instance A; drops Start after the accepting edge,
   // optionally re-pulses Start at step pulse_k, and checks Busy and output hold.
   task automatic wait_done_a(input string tag, input int pulse_k,
                              input logic [WA-1:0] pulse_val, output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
         if (k == pulse_k) begin
            start_a = 1'b1;
            din_a   = pulse_val;
         end else begin
            start_a = 1'b0;
         end
         if (k == 1) check({tag, " busy"}, 32'(busy_a), 32'd1);
         if (k == WA && !done_a) check({tag, " hold"}, 32'(bcd_a), prev_bcd_a);
      end while (!done_a && k < 40);
   endtask

   task automatic check_result_a(input string tag, input logic [WA-1:0] val, input int k);
      logic [31:0] e_bcd, e_mask;
      logic        e_ovf;
      ref_model(32'(val), DA, e_bcd, e_ovf, e_mask);
      check({tag, " latency"}, 32'(k), 32'(WA + 1));
      check({tag, " bcd"},     32'(bcd_a), e_bcd);
      check({tag, " ovf"},     32'(ovf_a), 32'(e_ovf));
      check({tag, " mask"},    32'(mask_a), e_mask);
      prev_bcd_a = e_bcd;
   endtask

   task automatic run_conv_a(input string tag, input logic [WA-1:0] val);
      int k;
      @(negedge clk);
      start_a = 1'b1;
      din_a   = val;
      wait_done_a(tag, 0, '0, k);
      check_result_a(tag, val, k);
   endtask

   task automatic run_conv_b(input logic [WB-1:0] val);
      logic [31:0] e_bcd, e_mask;
      logic        e_ovf;
      int          k;
      string       tag;
      tag = $sformatf("b%0d", val);
      ref_model(32'(val), DB, e_bcd, e_ovf, e_mask);
      @(negedge clk);
      start_b = 1'b1;
      din_b   = val;
      k = 0;
      do begin
         @(negedge clk);
         k++;
         start_b = 1'b0;
      end while (!done_b && k < 20);
      check({tag, " latency"}, 32'(k), 32'(WB + 1));
      check({tag, " bcd"},     32'(bcd_b), e_bcd);
      check({tag, " ovf"},     32'(ovf_b), 32'(e_ovf));
      check({tag, " mask"},    32'(mask_b), e_mask);
   endtask

   initial begin
      int            k;
      int            dones;
      logic [WA-1:0] directed [7];

      directed = '{14'd9999, 14'd10000, 14'd16383, 14'd0, 14'd42, 14'd1005, 14'd63};
      rst_n   = 1'b0;
      start_a = 1'b0;
      din_a   = '0;
      start_b = 1'b0;
      din_b   = '0;
      prev_bcd_a = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst busy",  32'(busy_a), 32'd0);
      check("rst done",  32'(done_a), 32'd0);
      check("rst bcd",   32'(bcd_a),  32'd0);
      check("rst ovf",   32'(ovf_a),  32'd0);
      check("rst mask",  32'(mask_a), 32'b1110);
      check("rst mask b", 32'(mask_b), 32'b10);
      rst_n = 1'b1;

      // Exhaustive sweep of the small instance
      for (int v = 0; v < 64; v++) run_conv_b(6'(v));

      // Directed boundaries and blank-mask cases
      foreach (directed[i]) run_conv_a($sformatf("dir%0d", directed[i]), directed[i]);

      // Random operands across the full input range
      for (int i = 0; i < 30; i++) begin
         logic [WA-1:0] r;
         r = 14'($urandom_range(0, (1 << WA) - 1));
         run_conv_a($sformatf("rnd%0d", r), r);
      end

      // Start pulsed mid-conversion is ignored and not queued
      @(negedge clk);
      start_a = 1'b1;
      din_a   = 14'd123;
      wait_done_a("mid", 5, 14'd456, k);
      check_result_a("mid", 14'd123, k);
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (done_a) dones++;
      end
      check("mid extra done", 32'(dones), 32'd0);
      check("mid bcd kept",   32'(bcd_a), 32'h0123);

      // Back-to-back: Start held across DONE restarts directly
      run_conv_a("b2b first", 14'd123);
      start_a = 1'b1;
      din_a   = 14'd456;
      wait_done_a("b2b second", 0, '0, k);
      check_result_a("b2b second", 14'd456, k);

      // Reset during SHIFT aborts the conversion
      @(negedge clk);
      start_a = 1'b1;
      din_a   = 14'd777;
      repeat (5) begin
         @(negedge clk);
         start_a = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (25) begin
         @(negedge clk);
         if (done_a) dones++;
      end
      check("abort done",  32'(dones),  32'd0);
      check("abort busy",  32'(busy_a), 32'd0);
      check("abort bcd",   32'(bcd_a),  32'd0);
      check("abort mask",  32'(mask_a), 32'b1110);
      prev_bcd_a = '0;
      run_conv_a("after abort", 14'd777);

      // Reset has priority over Start at the same edge
      @(negedge clk);
      rst_n   = 1'b0;
      start_a = 1'b1;
      din_a   = 14'd5;
      @(negedge clk);
      check("rst+start busy", 32'(busy_a), 32'd0);
      rst_n   = 1'b1;
      start_a = 1'b0;
      @(negedge clk);
      check("rst+start idle", 32'(busy_a), 32'd0);
      check("rst+start bcd",  32'(bcd_a),  32'd0);

      check("busy/done overlap", 32'(overlap), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bcd_converter.md
# bcd_converter

Parametrised sequential binary-to-packed-BCD converter (shift-add-3 / double-dabble) for arbitrary input width and digit count. It replaces a fixed 6-bit lookup-table conversion with one iteration per clock. It adds a start/done handshake, saturation with an overflow flag, and a leading-zero blank mask. It sits between the datapath and the four-digit seven-segment display driver; with DIGITS=4, BcdOut connects directly to the display's 16-bit data input.

## Interface
- WIDTH, 14, binary input width in bits; legal range ≥1.
- DIGITS, 4, number of BCD digits produced; legal range ≥1.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on the rising edge of Clk.
- Start  in  1  request a conversion of DataIn; sampled only while Busy=0.
- DataIn  in  WIDTH  unsigned binary operand; captured in the cycle Start is accepted.
- Busy  out  1  high while a conversion is in progress.
- Done  out  1  single-cycle pulse; BcdOut, Overflow and BlankMask are valid and updated in this cycle.
- BcdOut  out  4*DIGITS  packed BCD result; digit i occupies bits [4i+3:4i], digit 0 is least significant.
- Overflow  out  1  high when the captured value exceeds 10^DIGITS−1.
- BlankMask  out  DIGITS  bit i=1 means digit i is a leading zero and should be blanked.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: Busy=0, Done=0.
  - Start=1: capture DataIn into the shift register, clear the BCD scratch and the sticky overflow bit, load the iteration counter with WIDTH, then go to SHIFT.
- SHIFT: Busy=1. Each cycle performs one iteration:
  - For every scratch digit ≥5, add 3 (4-bit add; the result never exceeds 4'hC).
  - Shift {scratch, shift register} left by one bit.
  - The bit shifted out of the top digit sets sticky overflow.
  - Decrement the counter. When the counter reaches 1, the next state is DONE.
- DONE (one cycle): Busy=0, Done=1.
  - Output registers are loaded on the transition into DONE.
  - If overflow is set: BcdOut = all digits 4'h9 and Overflow=1.
  - Otherwise: BcdOut = scratch and Overflow=0.
  - BlankMask[i] = 1 iff digits i..DIGITS−1 of the loaded BcdOut are all zero, for i≥1. BlankMask[0] is always 0.
  - Next state is IDLE; if Start=1 in DONE, go directly to SHIFT and capture a new operand (back-to-back conversion).
- Start while Busy=1 is ignored; no queuing, and the operand is not re-sampled.
- BcdOut, Overflow and BlankMask hold their previous values for the whole conversion and change only when entering DONE.
- Iteration counter width: $clog2(WIDTH+1). The scratch register is 4*DIGITS bits.
- When DIGITS is large enough (10^DIGITS > 2^WIDTH−1), Overflow is never asserted; no special case is required.

## Timing
- Reset=0 at an edge forces, after that edge:
  - state IDLE, Busy=0, Done=0;
  - BcdOut=0, Overflow=0;
  - BlankMask = all ones except bit 0;
  - scratch and counter cleared.
- Reset mid-conversion aborts the conversion: no Done pulse, and outputs return to their reset values.
- Reset has priority over Start.
- Latency, with Start sampled at edge E0:
  - Busy rises after E0;
  - WIDTH SHIFT cycles follow;
  - Done is high for exactly the one cycle after edge E0+WIDTH;
  - results are valid from that cycle onward.
- Throughput: one conversion every WIDTH+1 cycles with Start held high.
- Done and Busy are never high simultaneously.

## Test plan
- WIDTH=6, DIGITS=2: Start with DataIn=63 → Done high in cycle 7 after Start, BcdOut=8'h63, Overflow=0, BlankMask=2'b00. Sweep all 0..63 against a reference model.
- WIDTH=14, DIGITS=4:
  - DataIn=9999 → BcdOut=16'h9999, Overflow=0.
  - DataIn=10000 → BcdOut=16'h9999, Overflow=1.
  - DataIn=16383 → BcdOut=16'h9999, Overflow=1.
- WIDTH=14, DIGITS=4 blank mask:
  - DataIn=0 → BcdOut=16'h0000, BlankMask=4'b1110.
  - DataIn=42 → BcdOut=16'h0042, BlankMask=4'b1100.
  - DataIn=1005 → BlankMask=4'b0000.
- Start with DataIn=123, then pulse Start with DataIn=456 mid-conversion → single Done, BcdOut=16'h0123. Then hold Start high across DONE with DataIn=456 → second Done exactly 15 cycles after the first, BcdOut=16'h0456.
- Reset=0 for one edge during SHIFT of a DataIn=777 conversion → no Done, BcdOut=0, Busy=0. A following Start with DataIn=777 → BcdOut=16'h0777 after 15 cycles.
- Reset=0 and Start=1 at the same edge → remains IDLE, Busy=0.
